// File: rtl/rom_stream_reader.sv
// rom_stream_reader: fetches a run of words from a 2^ADDR_W x DATA_W synchronous ROM and
// streams them out through a small FIFO, keeping a running checksum of delivered words.
module rom_stream_reader #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [DATA_W-1:0] checksum,
    output logic [1:0]        dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]  ONE_LEN = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W:0]    r_remain;
    logic [ADDR_W:0]    r_out_left;
    logic               r_inflight;
    logic               r_done;
    logic [DATA_W-1:0]  r_checksum;
    logic [DATA_W-1:0]  r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_accept;
    logic               w_room;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_out_last;
    logic               w_done_next;

    // Stream handshake: a word moves when out_valid & out_ready are both high at a rising
    // edge; while out_valid=1 and out_ready=0 the head word and its last flag stay put.
    assign out_valid  = (r_count != '0);
    assign out_data   = r_fifo[r_rd_ptr];
    assign w_out_last = out_valid && (r_out_left == ONE_LEN);
    assign out_last   = w_out_last;
    assign w_pop      = out_valid && out_ready;
    assign w_push     = r_inflight;

    // A read is issued only if its word is guaranteed a FIFO slot on arrival.
    assign w_room   = (r_count + CNT_W'(r_inflight)) < DEPTH_C;
    assign w_accept = (r_state == S_IDLE) && start;

    assign w_done_next = (w_accept && (length == '0)) ||
                         ((r_state == S_DRAIN) && w_pop && w_out_last);

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (length != '0)) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_room) begin
                    w_issue = 1'b1;
                    if (r_remain == ONE_LEN) begin
                        w_next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && w_out_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_remain   <= '0;
            r_out_left <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
            r_checksum <= '0;
        end else begin
            r_state    <= w_next_state;
            r_inflight <= w_issue;
            r_done     <= w_done_next;
            if (w_accept) begin
                r_checksum <= '0;
                r_addr     <= start_addr;
                r_remain   <= length;
                r_out_left <= length;
            end
            if (w_issue) begin
                r_addr   <= r_addr + ADDR_W'(1);
                r_remain <= r_remain - ONE_LEN;
            end
            if (w_pop) begin
                r_checksum <= r_checksum + out_data;
                r_out_left <= r_out_left - ONE_LEN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= rom_data;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(w_push && (r_count == DEPTH_C)));

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign rom_en    = w_issue;
    assign rom_addr  = w_issue ? r_addr : '0;
    assign checksum  = r_checksum;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: a ROM model feeds the reader; each scenario task drives a
// transfer and compares the delivered stream against words computed from the ROM formula.
`timescale 1ns/1ps
module tb_rom_stream_reader;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 3000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W:0]   length = '0;
    logic              busy;
    logic              done;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic [DATA_W-1:0] checksum;
    logic [1:0]        dbg_state;

    always #5 clk = ~clk;

    rom_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
        .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .checksum(checksum), .dbg_state(dbg_state)
    );

    // Synchronous ROM, built with the recursive rule; output forced to 0 without a read.
    logic [DATA_W-1:0] mem [64];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        for (int i = 16; i < 64; i++) mem[i] = mem[i-1] + 8'd2;
    end
    always @(posedge clk) rom_data <= rom_en ? mem[rom_addr] : '0;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    logic              got_last_q[$];
    int                n_rom_en, n_rom_en_stall, n_done, done_cyc;
    int                first_valid_cyc, first_xfer_cyc, last_xfer_cyc, hold_err;
    logic              busy_at_done, valid_seen, busy_seen, timed_out;
    logic [DATA_W-1:0] end_checksum;

    // Closed form of the ROM contents: i below 16, 2*i-15 from there on.
    function automatic logic [DATA_W-1:0] rom_word(input int a);
        if (a < 16) return 8'(a);
        return 8'(2 * a - 15);
    endfunction

    task automatic build_expect(input int addr, input int len, output logic [DATA_W-1:0] sum);
        exp_q.delete();
        sum = '0;
        for (int k = 0; k < len; k++) begin
            exp_q.push_back(rom_word((addr + k) % 64));
            sum = sum + rom_word((addr + k) % 64);
        end
    endtask

    // mode 0: ready always 1; mode 1: random ready; mode 2: ready low for stall_n cycles.
    task automatic run_transfer(input int addr, input int len, input int mode, input int stall_n,
                                input int abort_after, input bit noise);
        logic              prev_valid = 1'b0;
        logic              prev_ready = 1'b0;
        logic              prev_last = 1'b0;
        logic [DATA_W-1:0] prev_data = '0;
        got_q.delete();
        got_last_q.delete();
        n_rom_en = 0; n_rom_en_stall = 0; n_done = 0; done_cyc = -1; hold_err = 0;
        first_valid_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
        busy_at_done = 1'b0; valid_seen = 1'b0; busy_seen = 1'b0; timed_out = 1'b0;
        for (int cyc = 0; cyc < TIMEOUT; cyc++) begin
            @(posedge clk);
            #1;
            if (abort_after > 0 && got_q.size() == abort_after) begin
                rst_n = 1'b0;
                start = 1'b0;
                return;
            end
            if (cyc == 0) begin
                start = 1'b1;
                start_addr = 6'(addr);
                length = 7'(len);
            end else if (noise && got_q.size() < len && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                start_addr = 6'($urandom_range(0, 63));
                length = 7'($urandom_range(1, 64));
            end else begin
                start = 1'b0;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = (cyc >= stall_n);
            endcase
            @(negedge clk);
            if (prev_valid && !prev_ready &&
                (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
                hold_err++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid) valid_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
            if (rom_en) begin
                n_rom_en++;
                if (!out_ready) n_rom_en_stall++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_last_q.push_back(out_last);
                if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
            end
            prev_valid = out_valid; prev_ready = out_ready;
            prev_data = out_data;   prev_last = out_last;
            if (n_done > 0 && cyc >= done_cyc + 2) begin
                end_checksum = checksum;
                return;
            end
        end
        timed_out = 1'b1;
        end_checksum = checksum;
    endtask

    task automatic test_reset();
        #2;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b required 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b required 0", done); end
        n_vec++; if (rom_en !== 1'b0) begin n_err++; $display("FAIL reset_rom_en: got %0b required 0", rom_en); end
        n_vec++; if (rom_addr !== '0) begin n_err++; $display("FAIL reset_rom_addr: got %0h required 0", rom_addr); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %0b required 0", out_last); end
        n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %0h required 0", out_data); end
        n_vec++; if (checksum !== '0) begin n_err++; $display("FAIL reset_checksum: got %0h required 0", checksum); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] sum;
        build_expect(0, 4, sum);
        run_transfer(0, 4, 0, 0, 0, 1'b0);
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL basic_timeout: got %0b required 0", timed_out); end
        n_vec++; if (got_q.size() !== 4) begin n_err++; $display("FAIL basic_count: got %0d required 4", got_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_vec++;
            if (got_q[k] !== exp_q[k] || got_last_q[k] !== (k == exp_q.size() - 1)) begin
                n_err++;
                $display("FAIL basic_word%0d: got %0h/last %0b required %0h/last %0b", k, got_q[k], got_last_q[k], exp_q[k], (k == exp_q.size() - 1));
            end
        end
        n_vec++; if (end_checksum !== sum) begin n_err++; $display("FAIL basic_checksum: got %0h required %0h", end_checksum, sum); end
        n_vec++; if (first_valid_cyc !== 3) begin n_err++; $display("FAIL basic_latency: got %0d required 3", first_valid_cyc); end
        n_vec++; if (done_cyc !== last_xfer_cyc + 1) begin n_err++; $display("FAIL basic_done_cycle: got %0d required %0d", done_cyc, last_xfer_cyc + 1); end
        n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL basic_done_width: got %0d required 1", n_done); end
        n_vec++; if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done: got %0b required 0", busy_at_done); end
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] sum;
        build_expect(62, 4, sum);
        run_transfer(62, 4, 0, 0, 0, 1'b0);
        n_vec++; if (got_q.size() !== 4) begin n_err++; $display("FAIL wrap_count: got %0d required 4", got_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_vec++;
            if (got_q[k] !== exp_q[k] || got_last_q[k] !== (k == exp_q.size() - 1)) begin
                n_err++;
                $display("FAIL wrap_word%0d: got %0h/last %0b required %0h/last %0b", k, got_q[k], got_last_q[k], exp_q[k], (k == exp_q.size() - 1));
            end
        end
        n_vec++; if (end_checksum !== sum) begin n_err++; $display("FAIL wrap_checksum: got %0h required %0h", end_checksum, sum); end
    endtask

    task automatic test_full_rom();
        logic [DATA_W-1:0] sum;
        int bad = 0;
        build_expect(0, 64, sum);
        run_transfer(0, 64, 0, 0, 0, 1'b0);
        n_vec++; if (got_q.size() !== 64) begin n_err++; $display("FAIL full_count: got %0d required 64", got_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            if (got_q[k] !== exp_q[k] || got_last_q[k] !== (k == 63)) bad++;
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL full_words: got %0d bad words required 0", bad); end
        n_vec++; if (end_checksum !== sum) begin n_err++; $display("FAIL full_checksum: got %0h required %0h", end_checksum, sum); end
        n_vec++; if (last_xfer_cyc - first_xfer_cyc !== 63) begin n_err++; $display("FAIL full_bubbles: got span %0d required 63", last_xfer_cyc - first_xfer_cyc); end
        n_vec++; if (n_rom_en !== 64) begin n_err++; $display("FAIL full_rom_reads: got %0d required 64", n_rom_en); end
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] sum;
        build_expect(0, 8, sum);
        run_transfer(0, 8, 2, 10, 0, 1'b0);
        n_vec++; if (n_rom_en_stall > 4) begin n_err++; $display("FAIL stall_rom_reads: got %0d required at most 4", n_rom_en_stall); end
        n_vec++; if (hold_err !== 0) begin n_err++; $display("FAIL stall_hold: got %0d unstable cycles required 0", hold_err); end
        n_vec++; if (got_q.size() !== 8) begin n_err++; $display("FAIL stall_count: got %0d required 8", got_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_vec++;
            if (got_q[k] !== exp_q[k] || got_last_q[k] !== (k == exp_q.size() - 1)) begin
                n_err++;
                $display("FAIL stall_word%0d: got %0h/last %0b required %0h/last %0b", k, got_q[k], got_last_q[k], exp_q[k], (k == exp_q.size() - 1));
            end
        end
        n_vec++; if (end_checksum !== sum) begin n_err++; $display("FAIL stall_checksum: got %0h required %0h", end_checksum, sum); end
    endtask

    task automatic test_zero_length();
        run_transfer(9, 0, 0, 0, 0, 1'b0);
        n_vec++; if (done_cyc !== 1) begin n_err++; $display("FAIL zero_done_cycle: got %0d required 1", done_cyc); end
        n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL zero_done_width: got %0d required 1", n_done); end
        n_vec++; if (busy_seen !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %0b required 0", busy_seen); end
        n_vec++; if (valid_seen !== 1'b0) begin n_err++; $display("FAIL zero_valid: got %0b required 0", valid_seen); end
        n_vec++; if (end_checksum !== '0) begin n_err++; $display("FAIL zero_checksum: got %0h required 0", end_checksum); end
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] sum;
        int done_after = 0;
        build_expect(0, 16, sum);
        run_transfer(0, 16, 0, 0, 3, 1'b0);
        #1;
        n_vec++; if (got_q.size() !== 3) begin n_err++; $display("FAIL rmid_count: got %0d required 3", got_q.size()); end
        for (int k = 0; k < 3 && k < got_q.size(); k++) begin
            n_vec++;
            if (got_q[k] !== exp_q[k] || got_last_q[k] !== 1'b0) begin
                n_err++;
                $display("FAIL rmid_word%0d: got %0h/last %0b required %0h/last 0", k, got_q[k], got_last_q[k], exp_q[k]);
            end
        end
        n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0 || rom_en !== 1'b0)
            begin n_err++; $display("FAIL rmid_ctrl: got busy %0b valid %0b rom_en %0b required 0 0 0", busy, out_valid, rom_en); end
        n_vec++; if (checksum !== '0 || out_data !== '0)
            begin n_err++; $display("FAIL rmid_data: got checksum %0h data %0h required 0 0", checksum, out_data); end
        repeat (3) begin
            @(negedge clk);
            if (done) done_after++;
        end
        n_vec++; if (n_done + done_after !== 0) begin n_err++; $display("FAIL rmid_no_done: got %0d pulses required 0", n_done + done_after); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        build_expect(5, 2, sum);
        run_transfer(5, 2, 0, 0, 0, 1'b0);
        n_vec++; if (got_q.size() !== 2) begin n_err++; $display("FAIL rmid_restart_count: got %0d required 2", got_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_vec++;
            if (got_q[k] !== exp_q[k] || got_last_q[k] !== (k == 1)) begin
                n_err++;
                $display("FAIL rmid_restart_word%0d: got %0h/last %0b required %0h/last %0b", k, got_q[k], got_last_q[k], exp_q[k], (k == 1));
            end
        end
        n_vec++; if (end_checksum !== sum) begin n_err++; $display("FAIL rmid_restart_checksum: got %0h required %0h", end_checksum, sum); end
    endtask

    // Random start address, length and backpressure, with stray start pulses while busy.
    task automatic test_random();
        logic [DATA_W-1:0] sum;
        for (int t = 0; t < 10; t++) begin
            int addr = $urandom_range(0, 63);
            int len = $urandom_range(1, 64);
            build_expect(addr, len, sum);
            run_transfer(addr, len, 1, 0, 0, 1'b1);
            n_vec++;
            if (timed_out !== 1'b0 || got_q.size() !== len) begin
                n_err++;
                $display("FAIL rand%0d_count: got %0d words timeout %0b required %0d", t, got_q.size(), timed_out, len);
            end
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
                n_vec++;
                if (got_q[k] !== exp_q[k] || got_last_q[k] !== (k == len - 1)) begin
                    n_err++;
                    $display("FAIL rand%0d_word%0d: got %0h/last %0b required %0h/last %0b", t, k, got_q[k], got_last_q[k], exp_q[k], (k == len - 1));
                end
            end
            n_vec++; if (end_checksum !== sum) begin n_err++; $display("FAIL rand%0d_checksum: got %0h required %0h", t, end_checksum, sum); end
            n_vec++; if (hold_err !== 0) begin n_err++; $display("FAIL rand%0d_hold: got %0d required 0", t, hold_err); end
            n_vec++;
            if (n_done !== 1 || done_cyc !== last_xfer_cyc + 1 || busy_at_done !== 1'b0) begin
                n_err++;
                $display("FAIL rand%0d_done: got %0d pulses at %0d busy %0b required 1 at %0d busy 0", t, n_done, done_cyc, busy_at_done, last_xfer_cyc + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_full_rom();
        test_stall();
        test_zero_length();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
